// File: rtl/vsync_timing_gen.sv
// Vertical timing generator: counts LineEnd rising edges and produces vsync, vblank, line
// position and a frame-end pulse. Timing is reprogrammable via a shadow applied at frame wrap.
module vsync_timing_gen #(
  parameter int unsigned YW               = 10,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter int unsigned DEF_ACTIVE       = 480,
  parameter int unsigned DEF_FRONT        = 10,
  parameter int unsigned DEF_SYNC         = 2,
  parameter int unsigned DEF_BACK         = 33
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LineEnd,
  input  logic          enable,
  input  logic [YW-1:0] cfg_active,
  input  logic [YW-1:0] cfg_front,
  input  logic [YW-1:0] cfg_sync,
  input  logic [YW-1:0] cfg_back,
  input  logic          cfg_load,
  output logic          vsync,
  output logic          vblank,
  output logic [YW-1:0] yposition,
  output logic          frame_end,
  output logic          cfg_pending,
  output logic          cfg_error
);

  localparam int unsigned TW = YW + 2;
  localparam logic [TW-1:0] TMAX = {2'b01, {YW{1'b0}}};

  function automatic logic [TW-1:0] ext(input logic [YW-1:0] v);
    return {2'b00, v};
  endfunction

  logic          line_end_q;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] act_q, frt_q, syn_q, bck_q;
  logic [YW-1:0] act_d, frt_d, syn_d, bck_d;
  logic [YW-1:0] sh_act_q, sh_frt_q, sh_syn_q, sh_bck_q;
  logic          pend_q, pend_d, err_q, err_d;
  logic          vsync_q, vsync_d, vblank_q, vblank_d, fe_q;
  logic          adv, wrap, cfg_ok, in_sync;
  logic [TW-1:0] tot_live, cfg_tot, sync_lo, sync_hi;

  always_comb begin
    adv      = enable & LineEnd & ~line_end_q;
    tot_live = ext(act_q) + ext(frt_q) + ext(syn_q) + ext(bck_q);
    wrap     = adv && (ext(y_q) == tot_live - TW'(1));
    cfg_tot  = ext(cfg_active) + ext(cfg_front) + ext(cfg_sync) + ext(cfg_back);
    cfg_ok   = (cfg_active != '0) && (cfg_tot <= TMAX);

    // The shadow from before this edge is what a wrap applies.
    act_d = act_q;
    frt_d = frt_q;
    syn_d = syn_q;
    bck_d = bck_q;
    if (wrap && pend_q) begin
      act_d = sh_act_q;
      frt_d = sh_frt_q;
      syn_d = sh_syn_q;
      bck_d = sh_bck_q;
    end

    if (wrap) begin
      y_d = '0;
    end else if (adv) begin
      y_d = y_q + YW'(1);
    end else begin
      y_d = y_q;
    end

    // Outputs are decoded from the next line and next config so they stay aligned with y.
    sync_lo  = ext(act_d) + ext(frt_d);
    sync_hi  = sync_lo + ext(syn_d);
    in_sync  = (ext(y_d) >= sync_lo) && (ext(y_d) < sync_hi);
    vsync_d  = SYNC_ACTIVE_HIGH ? in_sync : ~in_sync;
    vblank_d = (y_d >= act_d);

    pend_d = pend_q;
    if (wrap) begin
      pend_d = 1'b0;
    end
    if (cfg_load && cfg_ok) begin
      pend_d = 1'b1;
    end
    err_d = cfg_load ? ~cfg_ok : err_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      line_end_q <= 1'b0;
      y_q        <= '0;
      act_q      <= YW'(DEF_ACTIVE);
      frt_q      <= YW'(DEF_FRONT);
      syn_q      <= YW'(DEF_SYNC);
      bck_q      <= YW'(DEF_BACK);
      sh_act_q   <= YW'(DEF_ACTIVE);
      sh_frt_q   <= YW'(DEF_FRONT);
      sh_syn_q   <= YW'(DEF_SYNC);
      sh_bck_q   <= YW'(DEF_BACK);
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      vsync_q    <= ~SYNC_ACTIVE_HIGH;
      vblank_q   <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      line_end_q <= LineEnd;
      y_q        <= y_d;
      act_q      <= act_d;
      frt_q      <= frt_d;
      syn_q      <= syn_d;
      bck_q      <= bck_d;
      if (cfg_load && cfg_ok) begin
        sh_act_q <= cfg_active;
        sh_frt_q <= cfg_front;
        sh_syn_q <= cfg_sync;
        sh_bck_q <= cfg_back;
      end
      pend_q     <= pend_d;
      err_q      <= err_d;
      vsync_q    <= vsync_d;
      vblank_q   <= vblank_d;
      fe_q       <= wrap;
    end
  end

  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign yposition   = y_q;
  assign frame_end   = fe_q;
  assign cfg_pending = pend_q;
  assign cfg_error   = err_q;

endmodule

// File: tb/tb_vsync_timing_gen.sv
// Scoreboard bench for vsync_timing_gen: stimulus queues hand-derived expected outputs,
// a negedge monitor pops and compares them once their cycle has arrived.
module tb_vsync_timing_gen;

  localparam int YW = 10;

  typedef struct {
    int    due;
    string tag;
    int    y;
    logic  vs, vb, fe, pend, err;
  } exp_t;

  logic          CLK = 1'b0, RESET = 1'b0, LineEnd = 1'b0, enable = 1'b1, cfg_load = 1'b0;
  logic [YW-1:0] cfg_active = '0, cfg_front = '0, cfg_sync = '0, cfg_back = '0;
  logic          vsync, vblank, frame_end, cfg_pending, cfg_error;
  logic [YW-1:0] yposition;

  int    cyc_n = 0, total = 0, bad = 0;
  int    cur_a = 480, cur_f = 10, cur_s = 2;
  logic  exp_pend = 1'b0, exp_err = 1'b0, rst_drv = 1'b0, en_drv = 1'b1;
  string tag = "reset";
  exp_t  q[$];

  vsync_timing_gen #(
    .YW(YW), .SYNC_ACTIVE_HIGH(1'b0), .DEF_ACTIVE(480), .DEF_FRONT(10), .DEF_SYNC(2),
    .DEF_BACK(33)
  ) dut (
    .CLK(CLK), .RESET(RESET), .LineEnd(LineEnd), .enable(enable),
    .cfg_active(cfg_active), .cfg_front(cfg_front), .cfg_sync(cfg_sync),
    .cfg_back(cfg_back), .cfg_load(cfg_load), .vsync(vsync), .vblank(vblank),
    .yposition(yposition), .frame_end(frame_end), .cfg_pending(cfg_pending),
    .cfg_error(cfg_error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  // Active-low sync pin: low exactly on lines A+F .. A+F+S-1 of the current timing.
  function automatic logic vs_of(input int y);
    return !((y >= cur_a + cur_f) && (y < cur_a + cur_f + cur_s));
  endfunction

  task automatic cyc(input logic le, input logic ld, input int ey, input logic efe);
    exp_t e;
    @(negedge CLK);
    RESET    = rst_drv;
    enable   = en_drv;
    LineEnd  = le;
    cfg_load = ld;
    e.due  = cyc_n + 1;
    e.tag  = tag;
    e.y    = ey;
    e.vs   = vs_of(ey);
    e.vb   = (ey >= cur_a);
    e.fe   = efe;
    e.pend = exp_pend;
    e.err  = exp_err;
    q.push_back(e);
  endtask

  task automatic line(input int ey, input logic efe);
    cyc(1'b1, 1'b0, ey, efe);
    cyc(1'b0, 1'b0, ey, 1'b0);
  endtask

  task automatic load(input int a, input int f, input int s, input int b, input int ey,
                      input logic ok);
    cfg_active = YW'(a);
    cfg_front  = YW'(f);
    cfg_sync   = YW'(s);
    cfg_back   = YW'(b);
    if (ok) begin
      exp_pend = 1'b1;
      exp_err  = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    cyc(1'b0, 1'b1, ey, 1'b0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc_n) begin
      e = q.pop_front();
      total++;
      if (int'(yposition) !== e.y || vsync !== e.vs || vblank !== e.vb ||
          frame_end !== e.fe || cfg_pending !== e.pend || cfg_error !== e.err) begin
        bad++;
        $display("FAIL %s @%0d: got y=%0d vs=%b vb=%b fe=%b pend=%b err=%b, want y=%0d vs=%b vb=%b fe=%b pend=%b err=%b",
                 e.tag, cyc_n, yposition, vsync, vblank, frame_end, cfg_pending, cfg_error,
                 e.y, e.vs, e.vb, e.fe, e.pend, e.err);
      end
    end
  end

  initial begin
    rst_drv = 1'b0;
    tag = "reset";
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);

    // LineEnd high on the first cycle out of reset, held 20 cycles: one advance only.
    rst_drv = 1'b1;
    tag = "hold";
    repeat (20) cyc(1'b1, 1'b0, 1, 1'b0);
    cyc(1'b0, 1'b0, 1, 1'b0);

    // Default frame of 525 lines with mid-frame loads (valid, invalid, T=1024 boundary).
    for (int i = 2; i <= 525; i++) begin
      int y;
      y = i % 525;
      tag = "frame0";
      if (i == 525) begin
        cur_a = 4; cur_f = 1; cur_s = 1;
        exp_pend = 1'b0;
        tag = "wrap0";
      end
      line(y, i == 525);
      if (y == 100) begin tag = "load_ok";   load(4, 1, 1, 2, 100, 1'b1); end
      if (y == 200) begin tag = "load_a0";   load(0, 5, 5, 5, 200, 1'b0); end
      if (y == 201) begin tag = "load_1025"; load(1000, 10, 5, 10, 201, 1'b0); end
      if (y == 300) begin tag = "load_1024"; load(1000, 10, 4, 10, 300, 1'b1); end
      if (y == 301) begin tag = "load_over"; load(4, 1, 1, 2, 301, 1'b1); end
    end

    // 8-line frame; X queued mid-frame, Y loaded on the wrap edge itself.
    for (int i = 1; i <= 8; i++) begin
      int y;
      y = i % 8;
      tag = "frame8";
      if (i == 8) begin
        cfg_active = 10'd3; cfg_front = 10'd0; cfg_sync = 10'd1; cfg_back = 10'd1;
        cur_a = 2; cur_f = 1; cur_s = 2;
        exp_pend = 1'b1;
        tag = "wrap_load";
        cyc(1'b1, 1'b1, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0);
      end else begin
        line(y, 1'b0);
      end
      if (y == 3) begin tag = "load_x"; load(2, 1, 2, 1, 3, 1'b1); end
    end

    // 6-line frame from X; its wrap applies Y.
    for (int i = 1; i <= 6; i++) begin
      tag = "frame6";
      if (i == 6) begin
        cur_a = 3; cur_f = 0; cur_s = 1;
        exp_pend = 1'b0;
        tag = "wrap6";
      end
      line(i % 6, i == 6);
    end

    // Rising edge while disabled is lost.
    tag = "enable";
    en_drv = 1'b0;
    line(0, 1'b0);
    en_drv = 1'b1;
    tag = "frame5";
    line(1, 1'b0);
    line(2, 1'b0);
    line(3, 1'b0);
    tag = "load_z";
    load(2, 2, 2, 2, 3, 1'b1);

    // Reset in a sync line with a pending config.
    rst_drv = 1'b0;
    cur_a = 480; cur_f = 10; cur_s = 2;
    exp_pend = 1'b0;
    exp_err = 1'b0;
    tag = "midreset";
    cyc(1'b0, 1'b0, 0, 1'b0);
    rst_drv = 1'b1;
    tag = "default";
    for (int i = 1; i <= 8; i++) line(i, 1'b0);

    repeat (3) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vsync_timing_gen.md
# vsync_timing_gen

Parametrised vertical timing generator: counts lines on the rising edge of the horizontal line-end strobe and produces vsync, vblank, line position and frame-end pulse for the video timer. It adds three things its fixed predecessor lacks: configurable counter width, selectable sync polarity, and run-time porch/sync/active reprogramming. New timing is written into a shadow register and takes effect only at a frame boundary, so a frame is never torn. It sits beside the horizontal sync generator and feeds the pixel/scan logic.

## Interface
- YW, 10: width of line counter and every timing field
- SYNC_ACTIVE_HIGH, 0: 1 = vsync pin high during sync lines, 0 = low during sync lines
- DEF_ACTIVE, 480: active lines loaded at reset
- DEF_FRONT, 10: front-porch lines loaded at reset
- DEF_SYNC, 2: sync lines loaded at reset
- DEF_BACK, 33: back-porch lines loaded at reset

- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- LineEnd  in  1  level strobe from the horizontal generator; each rising edge advances one line
- enable  in  1  1 = count lines; 0 = hold position (edge detector keeps tracking)
- cfg_active, cfg_front, cfg_sync, cfg_back  in  YW each  new timing fields
- cfg_load  in  1  one-cycle strobe capturing cfg_* into the shadow register
- vsync  out  1  sync pin, polarity per SYNC_ACTIVE_HIGH
- vblank  out  1  1 on every non-active line
- yposition  out  YW  current line, 0 = first active line
- frame_end  out  1  one-cycle pulse on wrap from last line to 0
- cfg_pending  out  1  shadow holds a valid config not yet applied
- cfg_error  out  1  last cfg_load rejected (sticky until next cfg_load)

## Operation
- Line order within a frame: Active (A), Front (F), Sync (S), Back (B). Total T = A+F+S+B lines; yposition runs 0..T-1.
- T is computed at YW+2 bits. A config is valid iff A ≥ 1 and T ≤ 2^YW.
- Advance condition: `adv = enable & LineEnd & ~LineEnd_q`, where LineEnd_q is the registered LineEnd.
- On adv: if yposition == T-1, then yposition ← 0, frame_end pulses, and the shadow (if cfg_pending) is copied to the live config with cfg_pending cleared. Otherwise yposition ← yposition+1.
- Sync lines: A+F ≤ y ≤ A+F+S-1, exactly S lines. If S = 0, vsync is never asserted.
- vblank = (y ≥ A), evaluated on the next y.
- cfg_load with a valid config: shadow ← cfg_*, cfg_pending ← 1, cfg_error ← 0. A second load before the frame boundary overwrites the shadow.
- cfg_load with an invalid config: shadow and live config are untouched, cfg_pending is unchanged, cfg_error ← 1.
- cfg_load on the same edge as a wrap: the wrap applies the shadow as it was before the edge, then the new load is written to the shadow, so it applies at the following wrap.
- Live config is unchanged mid-frame. Changing the config never moves yposition.

## Timing
- Reset (RESET=0 at an edge) sets:
  - yposition=0, frame_end=0, cfg_pending=0, cfg_error=0, vblank=0
  - vsync = deasserted level (~SYNC_ACTIVE_HIGH)
  - live config = DEF_*, LineEnd_q=0
- Reset mid-frame aborts the frame and discards any pending config.
- LineEnd held high after reset counts as a rising edge on the first cycle out of reset.
- Latency: LineEnd first sampled high at edge n (low at n-1) → yposition, vsync, vblank and frame_end all update at edge n. Every output is registered and aligned with yposition.
- frame_end is high for exactly one cycle, the cycle in which yposition first reads 0.
- A LineEnd held high for many cycles gives one advance. Consecutive rising edges need LineEnd low for ≥1 sampled cycle between them.
- enable=0 during a rising edge loses that line; no catch-up later.

## Test plan
- Defaults, YW=10, SYNC_ACTIVE_HIGH=0, 525 LineEnd pulses:
  - vsync low exactly at y=490,491
  - vblank high for y=480..524
  - frame_end once, at the 525th pulse, with y=0
- LineEnd held high 20 cycles, then low → yposition advances by exactly 1.
- Load A=4, F=1, S=1, B=2 at y=100 → cfg_pending=1, frame finishes at 525 lines; next frame is 8 lines with vsync at y=5 only; cfg_pending=0 after the wrap.
- Load A=0, or fields summing to 1025 (YW=10) → cfg_error=1, cfg_pending unchanged, timing unchanged. A following valid load clears cfg_error.
- cfg_load on the wrap edge with a different pending config → pending applied now, new one applied at the next wrap.
- Assert RESET mid-sync with a pending config → next cycle shows y=0, vsync=1, cfg_pending=0, and default timing resumes.
